alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
//
// PURPOSE
//   Shares one 32-bit ALU instance between NUM_REQ requesters using round-robin arbitration.
//   - Each requester presents operands a, b and a 4-bit alu_op with a valid/ready handshake.
//   - At most one request is granted per cycle.
//   - The result is registered and returned on one response channel, tagged with the requester ID.
//   - Sits between the issue/execute stages and the ALU wherever several units need ALU service.
//
// PARAMETERS
//   NUM_REQ   4                  number of requesters; legal range 2..16
//   ID_W      $clog2(NUM_REQ)    localparam; width of the requester tag
//
// PORTS
//   clk          in   1             clock; all state updates on the rising edge
//   rst          in   1             synchronous reset, active-high
//   req_valid    in   NUM_REQ       per-requester request valid
//   req_ready    out  NUM_REQ       per-requester grant; handshake = valid & ready
//   req_a        in   NUM_REQ*32    operand A, requester i at [32*i +: 32]
//   req_b        in   NUM_REQ*32    operand B, requester i at [32*i +: 32]
//   req_op       in   NUM_REQ*4     alu_op, requester i at [4*i +: 4]
//   rsp_valid    out  1             response valid
//   rsp_ready    in   1             consumer accepts the response
//   rsp_id       out  ID_W          index of the requester that owns the response
//   rsp_result   out  32            ALU result
//   rsp_err      out  1             1 = the request used an undefined alu_op
//
// BEHAVIOUR
//   - Reset values (synchronous, rst=1 at a clock edge):
//       rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, rr_ptr=0.
//     Reset in mid-operation discards any held response. rst has priority over every other event.
//   - Slot free condition: slot_free = !rsp_valid | rsp_ready.
//   - Grant selection: only when slot_free, pick the first i with req_valid[i]=1.
//     Search order is rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
//   - req_ready is one-hot or zero and is combinational from req_valid, rr_ptr and the output register state.
//   - req_ready[i] may be 1 only when req_valid[i]=1.
//   - No grant when slot_free=0 or no request is valid. rr_ptr is unchanged in that case.
//   - On a granted handshake at edge N, the following happen together:
//       * ALU output is captured into the output register.
//       * rsp_valid=1 from cycle N+1. Latency is exactly 1 cycle.
//       * rsp_id = granted index.
//       * rr_ptr = (granted index + 1) mod NUM_REQ. The granted requester gets lowest priority next.
//   - A drain (rsp_valid & rsp_ready) and a new grant in the same cycle is legal. Sustained throughput is 1 op per cycle.
//   - Drain with no new grant: rsp_valid=0 next cycle. rsp_id, rsp_result and rsp_err keep their values.
//   - Stall (rsp_valid=1, rsp_ready=0): rsp_id, rsp_result and rsp_err stay stable. No req_ready is asserted.
//   - ALU op encoding:
//       0000 a+b; 0001 a-b; 0010 a&b; 0011 a|b.
//       All arithmetic is modulo 2^32; no carry or overflow outputs.
//       Any other op gives result 0 and rsp_err=1. rsp_err=0 for the defined ops.
//   - Requesters must hold a, b and op stable while valid is high and not yet granted. The arbiter does not check this.
//
// STRUCTURE
//   - Shared package alu_pkg:
//       typedef enum logic [3:0] alu_op_e {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR}
//       function is_legal_op(alu_op_e)
//   - Instantiates the existing alu module once, fed by a combinational operand mux indexed by the grant.
//   - One natural sub-module: rr_arbiter #(N) (req, ptr -> one-hot gnt, gnt_idx).
//   - The output register and rr_ptr stay in this module.
//
// TESTING
//   1. Single op: req0 add a=5, b=3, rsp_ready=1
//      -> req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=8, rsp_err=0.
//   2. Full round-robin: all four req_valid held high, rsp_ready=1
//      -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_valid stays high and rsp_id follows one cycle later.
//   3. Backpressure: rsp_valid=1, rsp_ready=0 for 3 cycles with req1 valid
//      -> req_ready=0 and outputs stable.
//      Raise rsp_ready -> same cycle req_ready=0010; next cycle the new response appears.
//   4. Arithmetic and error: sub a=3, b=5 -> rsp_result=0xFFFFFFFE, rsp_err=0.
//      op=0111 -> rsp_result=0, rsp_err=1.
//   5. Reset mid-stream: assert rst while a response is stalled
//      -> next cycle rsp_valid=0, rsp_result=0.
//      After rst drops with req0 and req2 valid -> req0 is granted first (rr_ptr=0).
//   6. Pointer wrap: rr_ptr=3, req3 and req0 valid -> grant 3, then 0.
//      With only req1 valid -> req1 is granted immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, datapath widths and an
// op-legality helper used by the ALU and anything that issues to it.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011
    } alu_op_e;

    function automatic logic is_legal_op(input alu_op_e op);
        return op inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR};
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; undefined ops produce zero and flag err.
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    always_comb begin
        result = '0;
        case (alu_op_e'(op))
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = '0;
        endcase
        err = !is_legal_op(alu_op_e'(op));
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx
);

    logic found;

    // Search offsets in priority order; the first hit wins and blocks the rest.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = ID_W'(i);
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin arbitration and a
// single registered, ID-tagged response slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_a,
    input  logic [NUM_REQ*DATA_W-1:0]  req_b,
    input  logic [NUM_REQ*OP_W-1:0]    req_op,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]          rsp_result,
    output logic                       rsp_err
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    rr_ptr;
    logic               slot_free;
    logic [NUM_REQ-1:0] arb_req;
    logic [ID_W-1:0]    gnt_idx;
    logic               grant;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic [OP_W-1:0]    sel_op;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_err;

    // Requests are hidden from the arbiter while the response slot is occupied
    // and not draining, so no grant can be issued during a stall.
    assign slot_free = !rsp_valid || rsp_ready;
    assign arb_req   = slot_free ? req_valid : '0;
    assign grant     = |req_ready;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req     (arb_req),
        .ptr     (rr_ptr),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_a  = req_a[DATA_W*i +: DATA_W];
                sel_b  = req_b[DATA_W*i +: DATA_W];
                sel_op = req_op[OP_W*i +: OP_W];
            end
        end
    end

    alu u_alu (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (alu_result),
        .err    (alu_err)
    );

    // A grant refills the slot even when it drains in the same cycle; a drain
    // alone only clears valid, leaving the payload visible for debug.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            rr_ptr     <= '0;
        end else if (grant) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= gnt_idx;
            rsp_result <= alu_result;
            rsp_err    <= alu_err;
            rr_ptr     <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with four requesters.
module tb_alu_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*4-1:0]  req_op;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_result;
    logic          rsp_err;

    int assertions = 0;
    int failures   = 0;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[4*i +: 4]  = op;
        req_valid[i]      = 1'b1;
    endtask

    task automatic chk_ready(input string name, input logic [N-1:0] exp);
        #1;
        assertions++;
        if (req_ready !== exp) begin
            failures++;
            $display("[TB] FAIL %s: req_ready=%b expected %b", name, req_ready, exp);
        end
    endtask

    task automatic chk_rsp(input string name, input logic v, input logic [1:0] id,
                           input logic [31:0] res, input logic err);
        assertions++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_err} !== {v, id, res, err}) begin
            failures++;
            $display("[TB] FAIL %s: valid=%b id=%0d result=%h err=%b expected valid=%b id=%0d result=%h err=%b",
                     name, rsp_valid, rsp_id, rsp_result, rsp_err, v, id, res, err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_rsp("reset_outputs", 1'b0, 2'd0, 32'd0, 1'b0);
        chk_ready("reset_no_grant", 4'b0000);
    endtask

    task automatic test_single_op();
        set_req(0, 32'd5, 32'd3, 4'b0000);
        chk_ready("single_ready", 4'b0001);
        tick();
        req_valid = '0;
        chk_rsp("single_rsp", 1'b1, 2'd0, 32'd8, 1'b0);
        tick();
        chk_rsp("single_drain", 1'b0, 2'd0, 32'd8, 1'b0);
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'(i * 10), 32'd1, 4'b0000);
        for (int c = 0; c < 6; c++) begin
            chk_ready($sformatf("rr_ready_%0d", c), 4'(1 << (c % N)));
            tick();
            chk_rsp($sformatf("rr_rsp_%0d", c), 1'b1, 2'(c % N), 32'((c % N) * 10 + 1), 1'b0);
        end
        req_valid = '0;
        tick();
    endtask

    // rr_ptr is 2 on entry
    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(0, 32'd100, 32'd1, 4'b0000);
        chk_ready("bp_fill_ready", 4'b0001);
        tick();
        req_valid = '0;
        set_req(1, 32'd7, 32'd7, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            chk_ready($sformatf("bp_stall_ready_%0d", c), 4'b0000);
            tick();
            chk_rsp($sformatf("bp_stall_rsp_%0d", c), 1'b1, 2'd0, 32'd101, 1'b0);
        end
        rsp_ready = 1'b1;
        chk_ready("bp_release_ready", 4'b0010);
        tick();
        req_valid = '0;
        chk_rsp("bp_new_rsp", 1'b1, 2'd1, 32'd14, 1'b0);
        tick();
    endtask

    // rr_ptr is 2 on entry
    task automatic test_arith_err();
        set_req(2, 32'd3, 32'd5, 4'b0001);
        chk_ready("sub_ready", 4'b0100);
        tick();
        req_valid = '0;
        chk_rsp("sub_rsp", 1'b1, 2'd2, 32'hFFFF_FFFE, 1'b0);
        set_req(3, 32'd9, 32'd9, 4'b0111);
        chk_ready("err_ready", 4'b1000);
        tick();
        req_valid = '0;
        chk_rsp("err_rsp", 1'b1, 2'd3, 32'd0, 1'b1);
        set_req(0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b0010);
        chk_ready("and_ready", 4'b0001);
        tick();
        req_valid = '0;
        chk_rsp("and_rsp", 1'b1, 2'd0, 32'h00F0_000F, 1'b0);
        set_req(1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b0011);
        chk_ready("or_ready", 4'b0010);
        tick();
        req_valid = '0;
        chk_rsp("or_rsp", 1'b1, 2'd1, 32'hFFF0_0FFF, 1'b0);
        tick();
        chk_rsp("drain_holds", 1'b0, 2'd1, 32'hFFF0_0FFF, 1'b0);
    endtask

    // rr_ptr is 2 on entry; a stalled response is then wiped by reset
    task automatic test_reset_midstream();
        rsp_ready = 1'b0;
        set_req(3, 32'd1, 32'd1, 4'b0000);
        tick();
        req_valid = '0;
        tick();
        chk_rsp("mid_stalled", 1'b1, 2'd3, 32'd2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_rsp("mid_reset", 1'b0, 2'd0, 32'd0, 1'b0);
        rsp_ready = 1'b1;
        set_req(0, 32'd11, 32'd0, 4'b0000);
        set_req(2, 32'd22, 32'd0, 4'b0000);
        chk_ready("mid_first_grant", 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        chk_rsp("mid_rsp0", 1'b1, 2'd0, 32'd11, 1'b0);
        chk_ready("mid_second_grant", 4'b0100);
        tick();
        req_valid = '0;
        chk_rsp("mid_rsp2", 1'b1, 2'd2, 32'd22, 1'b0);
        tick();
    endtask

    // rr_ptr is 3 on entry
    task automatic test_pointer_wrap();
        set_req(3, 32'd30, 32'd3, 4'b0000);
        set_req(0, 32'd40, 32'd4, 4'b0000);
        chk_ready("wrap_grant3", 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        chk_rsp("wrap_rsp3", 1'b1, 2'd3, 32'd33, 1'b0);
        chk_ready("wrap_grant0", 4'b0001);
        tick();
        req_valid = '0;
        chk_rsp("wrap_rsp0", 1'b1, 2'd0, 32'd44, 1'b0);
        set_req(1, 32'd50, 32'd5, 4'b0001);
        chk_ready("wrap_only1", 4'b0010);
        tick();
        req_valid = '0;
        chk_rsp("wrap_rsp1", 1'b1, 2'd1, 32'd45, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_arith_err();
        test_reset_midstream();
        test_pointer_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
